gpio_irq_ctrl: RTL

Parametrised Wishbone GPIO controller with per-pin configurable interrupts and input debounce. It supports edge or level interrupts, polarity, both-edge detection, atomic output set/clear and a per-pin glitch filter. Shared pins owned by an alternate function are masked from interrupts. It sits on the uncore Wishbone bus and drives one interrupt line to the PLIC.

---
 rtl/gpio_irq_pkg.sv | 43 ++++
 rtl/gpio_debounce.sv | 44 ++++
 rtl/gpio_irq_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt controller: register word map,
// interrupt-type encoding and byte-lane merge helpers.
package gpio_irq_pkg;

    localparam int unsigned WB_DW         = 32;
    localparam int unsigned WB_AW         = 6;
    localparam int unsigned DEB_CNT_W_DEF = 8;

    localparam logic [3:0] ADR_IN      = 4'd0;
    localparam logic [3:0] ADR_OUT     = 4'd1;
    localparam logic [3:0] ADR_OE      = 4'd2;
    localparam logic [3:0] ADR_IO_SEL  = 4'd3;
    localparam logic [3:0] ADR_IE      = 4'd4;
    localparam logic [3:0] ADR_IS      = 4'd5;
    localparam logic [3:0] ADR_ITYPE   = 4'd6;
    localparam logic [3:0] ADR_IPOL    = 4'd7;
    localparam logic [3:0] ADR_IBOTH   = 4'd8;
    localparam logic [3:0] ADR_DEB_CFG = 4'd9;
    localparam logic [3:0] ADR_DEB_EN  = 4'd10;
    localparam logic [3:0] ADR_OUT_SET = 4'd11;
    localparam logic [3:0] ADR_OUT_CLR = 4'd12;
    localparam logic [3:0] ADR_LAST    = ADR_OUT_CLR;

    typedef enum logic {
        IT_EDGE  = 1'b0,
        IT_LEVEL = 1'b1
    } itype_e;

    // Expand the four byte enables to a 32-bit bit mask.
    function automatic logic [WB_DW-1:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Replace only the enabled byte lanes of old_val with data.
    function automatic logic [WB_DW-1:0] merge_lanes(input logic [WB_DW-1:0] old_val,
                                                     input logic [WB_DW-1:0] data,
                                                     input logic [3:0]       sel);
        logic [WB_DW-1:0] m;
        m = sel_mask(sel);
        return (old_val & ~m) | (data & m);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin glitch filter: the output only follows the input after it has
// differed from the held value for thresh consecutive cycles.
module gpio_debounce
    import gpio_irq_pkg::*;
#(
    parameter int unsigned CNT_W = DEB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] thresh,
    input  logic             din,
    output logic             dout
);

    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_active;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_active  = en && (thresh != '0);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // While bypassed the held value tracks the input so enabling is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (!w_active) begin
            r_stable <= din;
            r_cnt    <= '0;
        end else if (din == r_stable) begin
            r_cnt <= '0;
        end else if (w_cnt_inc == thresh) begin
            r_stable <= din;
            r_cnt    <= '0;
        end else begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign dout = w_active ? r_stable : din;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Wishbone GPIO controller with per-pin edge/level interrupts and optional
// input debounce (enabled by defining GPIO_DEBOUNCE_EN).
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int unsigned NO_OF_GPIO_PINS   = 32,
    parameter int unsigned NO_OF_SHARED_PINS = 15,
    parameter int unsigned DEB_CNT_W         = 8
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [WB_AW-1:0]             wb_adr_i,
    input  logic [WB_DW-1:0]             wb_dat_i,
    input  logic [3:0]                   wb_sel_i,
    output logic [WB_DW-1:0]             wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    input  logic [NO_OF_GPIO_PINS-1:0]   i_gpio,
    output logic [NO_OF_GPIO_PINS-1:0]   o_gpio,
    output logic [NO_OF_GPIO_PINS-1:0]   en_gpio,
    output logic [NO_OF_SHARED_PINS-1:0] io_sel,
    output logic                         wb_inta_o
);

    localparam int unsigned NP = NO_OF_GPIO_PINS;
    localparam int unsigned NS = NO_OF_SHARED_PINS;

    logic [3:0]       w_word;
    logic [1:0]       w_unused_adr;
    logic             w_req;
    logic             w_wr;
    logic             w_mapped;
    logic [WB_DW-1:0] w_wdat;
    logic             r_ack;
    logic             r_err;

    logic [NP-1:0] r_out;
    logic [NP-1:0] r_oe;
    logic [NS-1:0] r_io_sel;
    logic [NP-1:0] r_ie;
    logic [NP-1:0] r_is;
    logic [NP-1:0] r_itype;
    logic [NP-1:0] r_ipol;
    logic [NP-1:0] r_iboth;

    logic [NP-1:0] r_sync1;
    logic [NP-1:0] r_sync2;
    logic [NP-1:0] w_f;
    logic [NP-1:0] r_f_prev;
    logic [NP-1:0] w_raw;
    logic [NP-1:0] w_gate;
    logic [NP-1:0] r_evt;
    logic [NP-1:0] w_is_clr;

    logic [WB_DW-1:0] w_deb_cfg_rd;
    logic [WB_DW-1:0] w_deb_en_rd;
    logic [WB_DW-1:0] w_rdata;

    assign w_word       = wb_adr_i[5:2];
    assign w_unused_adr = wb_adr_i[1:0];
    assign w_mapped     = (w_word <= ADR_LAST);
    // A new request is only accepted while no response is on the bus.
    assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_wr         = w_req & wb_we_i;
    assign w_wdat       = wb_dat_i & sel_mask(wb_sel_i);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_req & w_mapped;
            r_err <= w_req & ~w_mapped;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;

    // Control registers, byte-lane writes.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_out    <= '0;
            r_oe     <= '1;
            r_io_sel <= '1;
            r_ie     <= '0;
            r_itype  <= '0;
            r_ipol   <= '0;
            r_iboth  <= '0;
        end else if (w_wr) begin
            case (w_word)
                ADR_OUT:     r_out    <= NP'(merge_lanes(32'(r_out), wb_dat_i, wb_sel_i));
                ADR_OE:      r_oe     <= NP'(merge_lanes(32'(r_oe), wb_dat_i, wb_sel_i));
                ADR_IO_SEL:  r_io_sel <= NS'(merge_lanes(32'(r_io_sel), wb_dat_i, wb_sel_i));
                ADR_IE:      r_ie     <= NP'(merge_lanes(32'(r_ie), wb_dat_i, wb_sel_i));
                ADR_ITYPE:   r_itype  <= NP'(merge_lanes(32'(r_itype), wb_dat_i, wb_sel_i));
                ADR_IPOL:    r_ipol   <= NP'(merge_lanes(32'(r_ipol), wb_dat_i, wb_sel_i));
                ADR_IBOTH:   r_iboth  <= NP'(merge_lanes(32'(r_iboth), wb_dat_i, wb_sel_i));
                ADR_OUT_SET: r_out    <= r_out | NP'(w_wdat);
                ADR_OUT_CLR: r_out    <= r_out & ~NP'(w_wdat);
                default: ;
            endcase
        end
    end

    assign o_gpio  = r_out;
    assign en_gpio = r_oe;
    assign io_sel  = r_io_sel;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_gpio;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_CNT_W-1:0] r_deb_cfg;
    logic [NP-1:0]        r_deb_en;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_deb_cfg <= '0;
            r_deb_en  <= '0;
        end else if (w_wr) begin
            if (w_word == ADR_DEB_CFG)
                r_deb_cfg <= DEB_CNT_W'(merge_lanes(32'(r_deb_cfg), wb_dat_i, wb_sel_i));
            if (w_word == ADR_DEB_EN)
                r_deb_en <= NP'(merge_lanes(32'(r_deb_en), wb_dat_i, wb_sel_i));
        end
    end

    for (genvar gi = 0; gi < int'(NP); gi++) begin : g_deb
        gpio_debounce #(
            .CNT_W (DEB_CNT_W)
        ) u_deb (
            .clk    (wb_clk_i),
            .rst_n  (wb_rst_ni),
            .en     (r_deb_en[gi]),
            .thresh (r_deb_cfg),
            .din    (r_sync2[gi]),
            .dout   (w_f[gi])
        );
    end

    assign w_deb_cfg_rd = 32'(r_deb_cfg);
    assign w_deb_en_rd  = 32'(r_deb_en);
`else
    assign w_f          = r_sync2;
    assign w_deb_cfg_rd = '0;
    assign w_deb_en_rd  = '0;
`endif

    // Raw per-pin event from the filtered input.
    always_comb begin
        w_raw = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (itype_e'(r_itype[i]) == IT_LEVEL)
                w_raw[i] = r_ipol[i] ? ~w_f[i] : w_f[i];
            else if (r_iboth[i])
                w_raw[i] = w_f[i] ^ r_f_prev[i];
            else if (r_ipol[i])
                w_raw[i] = ~w_f[i] & r_f_prev[i];
            else
                w_raw[i] = w_f[i] & ~r_f_prev[i];
        end
    end

    // Pins handed to the alternate function never raise interrupts.
    always_comb begin
        w_gate = '1;
        for (int unsigned i = 0; i < NS; i++) begin
            w_gate[i] = ~r_io_sel[i];
        end
    end

    assign w_is_clr = (w_wr && (w_word == ADR_IS)) ? NP'(w_wdat) : '0;

    // A set beats a same-cycle clear for edges; a level clear shows for one
    // cycle before the still-active source sets the bit again.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_f_prev <= '0;
            r_evt    <= '0;
            r_is     <= '0;
        end else begin
            r_f_prev <= w_f;
            r_evt    <= w_raw & r_ie & w_gate;
            r_is     <= (r_is & ~w_is_clr) | (r_evt & ~(w_is_clr & r_itype));
        end
    end

    assign wb_inta_o = |(r_is & r_ie);

    always_comb begin
        w_rdata = '0;
        case (w_word)
            ADR_IN:      w_rdata = 32'(w_f);
            ADR_OUT:     w_rdata = 32'(r_out);
            ADR_OE:      w_rdata = 32'(r_oe);
            ADR_IO_SEL:  w_rdata = 32'(r_io_sel);
            ADR_IE:      w_rdata = 32'(r_ie);
            ADR_IS:      w_rdata = 32'(r_is);
            ADR_ITYPE:   w_rdata = 32'(r_itype);
            ADR_IPOL:    w_rdata = 32'(r_ipol);
            ADR_IBOTH:   w_rdata = 32'(r_iboth);
            ADR_DEB_CFG: w_rdata = w_deb_cfg_rd;
            ADR_DEB_EN:  w_rdata = w_deb_en_rd;
            default:     w_rdata = '0;
        endcase
    end

    assign wb_dat_o = w_rdata;

endmodule
